split_bus_arbiter: RTL and testbench
====================================

# split_bus_arbiter

Central arbiter for the serial system bus. It grants bus ownership to one master port at a time and supports one outstanding split transaction: a parked master is released, then re-granted with top priority when the slave is ready. It sits between the master ports' mbreq/mbgrant/msplit pins and the address-decoder/slave side, and drives the select index used by the bus write/read muxes.

## Interface
- NUM_MASTERS, 2, number of master ports; legal range 2..4
- SEL_WIDTH, 2, width of msel; must satisfy 2**SEL_WIDTH >= NUM_MASTERS

- clk  in  1  bus clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- mbreq  in  NUM_MASTERS  per-master bus request, level, held for whole transaction
- mbgrant  out  NUM_MASTERS  one-hot (or zero) grant, registered
- msplit  out  NUM_MASTERS  split-parked indication per master, registered
- msel  out  SEL_WIDTH  index of current owner; valid only while bus_busy=1
- bus_busy  out  1  any grant asserted
- ssplit  in  1  slave requests split of current transaction, single-cycle pulse
- split_done  in  1  split slave ready to resume, single-cycle pulse

## Operation
- States: IDLE, BUSY. Registers: owner, split_pend, split_owner, last_grant.
- Reset: state=IDLE; mbgrant=0, msplit=0, msel=0, bus_busy=0, split_pend=0, split_ready=0, last_grant=NUM_MASTERS-1.
- Eligible set = mbreq with split_owner masked off while split_pend=1.
- IDLE: if split_ready=1 and mbreq[split_owner]=1 -> grant split_owner, clear msplit[split_owner], split_pend, split_ready; -> BUSY. Else if eligible set nonzero -> grant winner of picker; -> BUSY. Else stay.
- BUSY: if mbreq[owner]=0 -> drop grant, -> IDLE, last_grant<=owner. Else if ssplit=1 and split_pend=0 -> msplit[owner]<=1, split_pend<=1, split_owner<=owner, drop grant, -> IDLE. ssplit while split_pend=1 ignored (grant held).
- split_done while split_pend=1 sets split_ready in any state; split_done while split_pend=0 ignored.
- Split master that drops mbreq while parked: split_pend, split_ready and msplit cleared next cycle (abandoned transaction).
- Ownership never preempted except by ssplit.

## Timing
- Request seen in IDLE at edge t -> mbgrant/msel/bus_busy valid after edge t (1-cycle latency).
- Owner drops mbreq before edge t -> grant low after t; next grant earliest after t+1 (one mandatory IDLE turnaround cycle).
- ssplit sampled at edge t -> grant low and msplit high after t; other master grantable after t+1.
- Re-grant: msplit low and mbgrant high in the same cycle, so master sees !msplit && mbgrant together.
- ssplit and owner-release on the same edge: release wins, ssplit ignored.
- split_done and ssplit on same edge with split_pend=0: ssplit processed, split_done dropped.
- Reset mid-transaction: all outputs and pending split state cleared on that edge.

## Configuration
- ARB_ROUND_ROBIN_EN defined: winner = first eligible index after last_grant, wrapping modulo NUM_MASTERS.
- Undefined: fixed priority, lowest eligible index wins; last_grant still maintained but unused.
- Split priority override identical in both builds.

## Structure
- Shared package bus_pkg: arbiter state encoding, NUM_MASTERS_MAX=4, index width function.
- One sub-module arb_picker: combinational, inputs eligible vector and last_grant, outputs winner index and valid; macro selects algorithm inside it.

## Test plan
- Only M0 requests -> mbgrant=2'b01, msel=0 one cycle later; M0 drops -> grant 0 next cycle.
- M0 and M1 request together, round-robin build, from reset -> M0 granted, then after release M1 (one IDLE cycle between); fixed-priority build -> M0 again while it re-requests.
- M0 owns, ssplit pulse -> msplit=2'b01, grant dropped; M1 requesting -> M1 granted 2 cycles after ssplit.
- split_done during M1 ownership -> M0 waits; M1 releases -> M0 re-granted with msplit[0]=0 same cycle, ahead of a pending M1 re-request.
- Second ssplit while split pending -> ignored, owner keeps grant.
- rstn low while M1 owns with M0 parked -> mbgrant=0, msplit=0, bus_busy=0 after that edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: arbiter state encoding,
// master-count limit and index-width helper.
package bus_pkg;

  localparam int unsigned NUM_MASTERS_MAX = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection over the eligible request vector.
// ARB_ROUND_ROBIN_EN selects round-robin after last_grant; otherwise lowest index wins.
module arb_picker
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned SEL_WIDTH   = 2
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic [SEL_WIDTH-1:0]   last_grant,
  output logic [SEL_WIDTH-1:0]   winner,
  output logic                   valid
);

  logic [NUM_MASTERS-1:0] shifted;
  int unsigned            idx;

`ifdef ARB_ROUND_ROBIN_EN
  // Scan starts one past the previous owner and wraps, so it is visited last.
  always_comb begin
    winner  = '0;
    valid   = 1'b0;
    shifted = '0;
    idx     = 0;
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      idx     = (int'(last_grant) + off) % NUM_MASTERS;
      shifted = eligible >> idx;
      if (!valid && shifted[0]) begin
        valid  = 1'b1;
        winner = SEL_WIDTH'(idx);
      end
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    winner  = '0;
    valid   = 1'b0;
    shifted = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx     = i;
      shifted = eligible >> idx;
      if (!valid && shifted[0]) begin
        valid  = 1'b1;
        winner = SEL_WIDTH'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/split_bus_arbiter.sv
// Central bus arbiter with one outstanding split transaction.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin picking (default fixed priority).
module split_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned SEL_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] mbreq,
  output logic [NUM_MASTERS-1:0] mbgrant,
  output logic [NUM_MASTERS-1:0] msplit,
  output logic [SEL_WIDTH-1:0]   msel,
  output logic                   bus_busy,
  input  logic                   ssplit,
  input  logic                   split_done
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > NUM_MASTERS_MAX ||
      SEL_WIDTH < idx_width(NUM_MASTERS)) begin : g_bad_cfg
    $error("split_bus_arbiter: illegal NUM_MASTERS/SEL_WIDTH");
  end

  arb_state_t             state;
  logic [SEL_WIDTH-1:0]   owner;
  logic [SEL_WIDTH-1:0]   split_owner;
  logic [SEL_WIDTH-1:0]   last_grant;
  logic                   split_pend;
  logic                   split_ready;

  logic [NUM_MASTERS-1:0] owner_hot;
  logic [NUM_MASTERS-1:0] split_hot;
  logic [NUM_MASTERS-1:0] win_hot;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   owner_req;
  logic                   split_req;
  logic [SEL_WIDTH-1:0]   winner;
  logic                   win_valid;

  always_comb begin
    owner_hot = '0;
    split_hot = '0;
    win_hot   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      owner_hot[i] = (owner == SEL_WIDTH'(i));
      split_hot[i] = (split_owner == SEL_WIDTH'(i));
      win_hot[i]   = (winner == SEL_WIDTH'(i));
    end
    owner_req = |(mbreq & owner_hot);
    split_req = |(mbreq & split_hot);
    eligible  = mbreq & ~(split_pend ? split_hot : '0);
  end

  arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .SEL_WIDTH   (SEL_WIDTH)
  ) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant),
    .winner     (winner),
    .valid      (win_valid)
  );

  // Later assignments override earlier ones: an abandoned park beats a same-edge split_done.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      mbgrant     <= '0;
      msplit      <= '0;
      msel        <= '0;
      bus_busy    <= 1'b0;
      owner       <= '0;
      split_owner <= '0;
      split_pend  <= 1'b0;
      split_ready <= 1'b0;
      last_grant  <= SEL_WIDTH'(NUM_MASTERS - 1);
    end else begin
      if (split_pend && split_done) begin
        split_ready <= 1'b1;
      end
      if (split_pend && !split_req) begin
        split_pend  <= 1'b0;
        split_ready <= 1'b0;
        msplit      <= msplit & ~split_hot;
      end
      case (state)
        IDLE: begin
          if (split_ready && split_req) begin
            owner       <= split_owner;
            msel        <= split_owner;
            mbgrant     <= split_hot;
            bus_busy    <= 1'b1;
            msplit      <= msplit & ~split_hot;
            split_pend  <= 1'b0;
            split_ready <= 1'b0;
            state       <= BUSY;
          end else if (win_valid) begin
            owner    <= winner;
            msel     <= winner;
            mbgrant  <= win_hot;
            bus_busy <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            mbgrant    <= '0;
            bus_busy   <= 1'b0;
            last_grant <= owner;
            state      <= IDLE;
          end else if (ssplit && !split_pend) begin
            msplit      <= msplit | owner_hot;
            split_pend  <= 1'b1;
            split_owner <= owner;
            mbgrant     <= '0;
            bus_busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Self-checking bench for split_bus_arbiter: directed scenarios then random traffic,
// compared every cycle against a behavioural model of the arbitration rules.
module tb_split_bus_arbiter;

  localparam int NM = 2;
  localparam int SW = 2;

  logic          clk;
  logic          rstn;
  logic [NM-1:0] mbreq;
  logic [NM-1:0] mbgrant;
  logic [NM-1:0] msplit;
  logic [SW-1:0] msel;
  logic          bus_busy;
  logic          ssplit;
  logic          split_done;

  int checks   = 0;
  int failures = 0;

  // Model: owner/parked are master numbers, -1 meaning none.
  int m_owner  = -1;
  int m_parked = -1;
  bit m_ready  = 1'b0;
  int m_last   = NM - 1;

  split_bus_arbiter #(
    .NUM_MASTERS (NM),
    .SEL_WIDTH   (SW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mbreq      (mbreq),
    .mbgrant    (mbgrant),
    .msplit     (msplit),
    .msel       (msel),
    .bus_busy   (bus_busy),
    .ssplit     (ssplit),
    .split_done (split_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [NM-1:0] req, input int parked, input int last);
    int w;
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int off = 1; off <= NM; off++) begin
      int i;
      i = (last + off) % NM;
      if (w < 0 && req[i] && i != parked) w = i;
    end
`else
    for (int i = 0; i < NM; i++)
      if (w < 0 && req[i] && i != parked) w = i;
`endif
    return w;
  endfunction

  task automatic model_step();
    int n_owner, n_parked, n_last;
    bit n_ready;
    if (!rstn) begin
      m_owner = -1; m_parked = -1; m_ready = 1'b0; m_last = NM - 1;
      return;
    end
    n_owner = m_owner; n_parked = m_parked; n_ready = m_ready; n_last = m_last;
    if (m_parked >= 0 && split_done) n_ready = 1'b1;
    if (m_parked >= 0 && !mbreq[m_parked]) begin
      n_parked = -1; n_ready = 1'b0;
    end
    if (m_owner < 0) begin
      if (m_ready && m_parked >= 0 && mbreq[m_parked]) begin
        n_owner = m_parked; n_parked = -1; n_ready = 1'b0;
      end else begin
        n_owner = pick(mbreq, m_parked, m_last);
      end
    end else if (!mbreq[m_owner]) begin
      n_owner = -1; n_last = m_owner;
    end else if (ssplit && m_parked < 0) begin
      n_parked = m_owner; n_owner = -1;
    end
    m_owner = n_owner; m_parked = n_parked; m_ready = n_ready; m_last = n_last;
  endtask

  task automatic check_outputs(input string tag);
    logic [NM-1:0] eg, es;
    logic [SW-1:0] esel;
    logic          eb;
    eg   = (m_owner >= 0) ? NM'(1 << m_owner) : '0;
    es   = (m_parked >= 0) ? NM'(1 << m_parked) : '0;
    eb   = (m_owner >= 0);
    esel = (m_owner >= 0) ? SW'(m_owner) : '0;
    checks++;
    assert (mbgrant === eg) else begin
      failures++;
      $error("FAIL %s mbgrant observed=%b expected=%b", tag, mbgrant, eg);
    end
    checks++;
    assert (msplit === es) else begin
      failures++;
      $error("FAIL %s msplit observed=%b expected=%b", tag, msplit, es);
    end
    checks++;
    assert (bus_busy === eb) else begin
      failures++;
      $error("FAIL %s bus_busy observed=%b expected=%b", tag, bus_busy, eb);
    end
    if (eb) begin
      checks++;
      assert (msel === esel) else begin
        failures++;
        $error("FAIL %s msel observed=%0d expected=%0d", tag, msel, esel);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
    ssplit     = 1'b0;
    split_done = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; mbreq = '0; ssplit = 1'b0; split_done = 1'b0;
    tick("reset0");
    tick("reset1");
    checks++;
    assert (mbgrant === 2'b00 && msplit === 2'b00 && bus_busy === 1'b0 && msel === 2'b00) else begin
      failures++;
      $error("FAIL reset_const observed=%b/%b/%b/%0d expected=00/00/0/0", mbgrant, msplit, bus_busy, msel);
    end
    rstn = 1'b1;
    tick("idle");

    // Single requester: grant after one edge, drop after one edge.
    mbreq = 2'b01; tick("m0_req");
    tick("m0_hold");
    mbreq = 2'b00; tick("m0_drop");
    tick("idle2");

    // Two requesters; M0 re-requests during the turnaround cycle.
    mbreq = 2'b11; tick("both0");
    tick("both1");
    mbreq = 2'b10; tick("m0_release");
    mbreq = 2'b11; tick("after_turn");
    tick("after_turn2");
    mbreq = 2'b00; tick("clear0");
    tick("clear1");

    // Split: M0 parked, M1 takes the bus, second ssplit ignored.
    mbreq = 2'b01; tick("own_m0");
    mbreq = 2'b11; ssplit = 1'b1; tick("split_m0");
    tick("m1_grant");
    tick("m1_hold");
    ssplit = 1'b1; tick("ssplit_ignored");
    split_done = 1'b1; tick("split_done");
    tick("m0_waits");
    mbreq = 2'b01; tick("m1_release");
    mbreq = 2'b11; tick("m0_regrant");
    tick("m0_owns");
    mbreq = 2'b10; tick("m0_done");
    tick("m1_next");

    // Reset while M1 owns and M0 is parked.
    mbreq = 2'b00; tick("drain0");
    tick("drain1");
    mbreq = 2'b01; tick("own_m0b");
    mbreq = 2'b11; ssplit = 1'b1; tick("split_m0b");
    tick("m1_grantb");
    rstn = 1'b0; tick("mid_reset");
    rstn = 1'b1; mbreq = 2'b00; tick("post_reset");

    // Parked master abandons its transaction.
    mbreq = 2'b01; tick("own_m0c");
    mbreq = 2'b11; ssplit = 1'b1; tick("split_m0c");
    mbreq = 2'b10; split_done = 1'b1; tick("abandon");
    tick("abandon2");

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NM; i++)
        if ($urandom_range(5) == 0) mbreq[i] = ~mbreq[i];
      ssplit     = ($urandom_range(4) == 0);
      split_done = ($urandom_range(7) == 0);
      rstn       = ($urandom_range(299) != 0);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
